// File: rtl/sample_modulation_az_sequencer.sv
// Auto-zero sample sequencer: alternates the ADC input between signal (HI) and
// the az reference (LO), with precharge guard delays, an ADC watchdog and an MCU interrupt.
module sample_modulation_az_sequencer #(
    parameter int unsigned         ADC_TIMEOUT_CLKS = 2000000,
    parameter int unsigned         PRECHARGE_CLKS   = 10000,
    parameter int                  AZMUX_W          = 4,
    parameter logic [AZMUX_W-1:0]  AZMUX_HI_VAL     = 4'b1000,
    parameter logic                SW_PC_SIGNAL     = 1'b1,
    parameter logic                SW_PC_BOOT       = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [AZMUX_W-1:0] azmux_lo_val,
    input  logic               adc_measure_valid,
    output logic               adc_measure_trig,
    output logic               sw_pc_ctl,
    output logic [AZMUX_W-1:0] azmux,
    output logic               sample_phase,
    output logic               led0,
    output logic [1:0]         monitor,
    output logic               spi_interrupt_ctl,
    output logic               fault
);

    typedef enum logic [3:0] {
        S_IDLE, S_PC_BOOT, S_PC_BOOT_W, S_HI_SETTLE, S_HI_SETTLE_W, S_HI_TRIG,
        S_HI_WAIT, S_LO_SETTLE_W, S_LO_TRIG, S_LO_WAIT, S_FAULT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_count, w_count_nxt;
    logic               r_trig, w_trig_nxt;
    logic               r_sw_pc, w_sw_pc_nxt;
    logic [AZMUX_W-1:0] r_azmux, w_azmux_nxt;
    logic               r_phase, w_phase_nxt;
    logic               r_led, w_led_nxt;
    logic [1:0]         r_mon, w_mon_nxt;
    logic               r_fault, w_fault_nxt;
    logic [1:0]         r_edge;
    logic               r_spi;
    logic               w_valid_ok;
    logic               w_zero;

    // A valid level still high from the previous measure must not satisfy the trig clk.
    assign w_valid_ok = adc_measure_valid && !r_trig;
    assign w_zero     = (r_count == 32'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count - 32'd1;
        w_trig_nxt  = r_trig;
        w_sw_pc_nxt = r_sw_pc;
        w_azmux_nxt = r_azmux;
        w_phase_nxt = r_phase;
        w_led_nxt   = r_led;
        w_mon_nxt   = r_mon;
        w_fault_nxt = r_fault;
        case (r_state)
            S_IDLE: begin
                w_sw_pc_nxt = SW_PC_BOOT;
                w_azmux_nxt = azmux_lo_val;
                if (run) w_state_nxt = S_PC_BOOT;
            end
            S_PC_BOOT: begin
                w_count_nxt = 32'(PRECHARGE_CLKS);
                w_sw_pc_nxt = SW_PC_BOOT;
                w_state_nxt = S_PC_BOOT_W;
            end
            S_PC_BOOT_W: if (w_zero) w_state_nxt = S_HI_SETTLE;
            S_HI_SETTLE: begin
                w_azmux_nxt  = AZMUX_HI_VAL;
                w_mon_nxt[0] = 1'b1;
                w_count_nxt  = 32'(PRECHARGE_CLKS);
                w_state_nxt  = S_HI_SETTLE_W;
            end
            S_HI_SETTLE_W: if (w_zero) w_state_nxt = S_HI_TRIG;
            S_HI_TRIG: begin
                w_sw_pc_nxt  = SW_PC_SIGNAL;
                w_phase_nxt  = 1'b0;
                w_trig_nxt   = 1'b1;
                w_mon_nxt[1] = 1'b1;
                w_count_nxt  = 32'(ADC_TIMEOUT_CLKS);
                w_state_nxt  = S_HI_WAIT;
            end
            S_HI_WAIT: begin
                w_trig_nxt = 1'b0;
                if (w_valid_ok) begin
                    w_sw_pc_nxt  = SW_PC_BOOT;
                    w_mon_nxt[1] = 1'b0;
                    w_count_nxt  = 32'(PRECHARGE_CLKS);
                    w_state_nxt  = S_LO_SETTLE_W;
                end else if (w_zero) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_LO_SETTLE_W: begin
                if (w_zero) begin
                    w_azmux_nxt  = azmux_lo_val;
                    w_mon_nxt[0] = 1'b0;
                    w_state_nxt  = S_LO_TRIG;
                end
            end
            S_LO_TRIG: begin
                w_phase_nxt  = 1'b1;
                w_trig_nxt   = 1'b1;
                w_mon_nxt[1] = 1'b1;
                w_count_nxt  = 32'(ADC_TIMEOUT_CLKS);
                w_state_nxt  = S_LO_WAIT;
            end
            S_LO_WAIT: begin
                w_trig_nxt = 1'b0;
                if (w_valid_ok) begin
                    w_mon_nxt[1] = 1'b0;
                    w_led_nxt    = ~r_led;
                    w_state_nxt  = run ? S_HI_SETTLE : S_IDLE;
                end else if (w_zero) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
        // Fault outputs take effect on the same edge the watchdog expires.
        if (w_state_nxt == S_FAULT) begin
            w_fault_nxt = 1'b1;
            w_sw_pc_nxt = SW_PC_BOOT;
            w_azmux_nxt = azmux_lo_val;
            w_trig_nxt  = 1'b0;
            w_mon_nxt   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 32'd0;
            r_trig  <= 1'b0;
            r_sw_pc <= SW_PC_BOOT;
            r_azmux <= azmux_lo_val;
            r_phase <= 1'b0;
            r_led   <= 1'b0;
            r_mon   <= 2'b00;
            r_fault <= 1'b0;
            r_edge  <= 2'b00;
            r_spi   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_trig  <= w_trig_nxt;
            r_sw_pc <= w_sw_pc_nxt;
            r_azmux <= w_azmux_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
            r_mon   <= w_mon_nxt;
            r_fault <= w_fault_nxt;
            r_edge  <= {r_edge[0], adc_measure_valid};
            r_spi   <= (r_edge != 2'b01);
        end
    end

    assign adc_measure_trig  = r_trig;
    assign sw_pc_ctl         = r_sw_pc;
    assign azmux             = r_azmux;
    assign sample_phase      = r_phase;
    assign led0              = r_led;
    assign monitor           = r_mon;
    assign spi_interrupt_ctl = r_spi;
    assign fault             = r_fault;

endmodule

// File: tb/tb_sample_modulation_az_sequencer.sv
// Directed bench for the auto-zero sequencer, short precharge and timeout settings.
module tb_sample_modulation_az_sequencer;

    localparam logic [3:0] HI   = 4'b1000;
    localparam logic       SIG  = 1'b1;
    localparam logic       BOOT = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] lo_val;
    logic       valid;
    logic       trig;
    logic       sw_pc;
    logic [3:0] azmux;
    logic       phase;
    logic       led0;
    logic [1:0] monitor;
    logic       spi;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    sample_modulation_az_sequencer #(
        .ADC_TIMEOUT_CLKS(20),
        .PRECHARGE_CLKS  (4),
        .AZMUX_W         (4),
        .AZMUX_HI_VAL    (HI),
        .SW_PC_SIGNAL    (SIG),
        .SW_PC_BOOT      (BOOT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .azmux_lo_val     (lo_val),
        .adc_measure_valid(valid),
        .adc_measure_trig (trig),
        .sw_pc_ctl        (sw_pc),
        .azmux            (azmux),
        .sample_phase     (phase),
        .led0             (led0),
        .monitor          (monitor),
        .spi_interrupt_ctl(spi),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // n = edges until trig seen (-1 if never); sig = sw_pc was SIGNAL before trig
    task automatic wait_trig(input int max, output int n, output bit sig);
        n   = -1;
        sig = 1'b0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (trig === 1'b1) begin
                n = i;
                break;
            end
            if (sw_pc === SIG) sig = 1'b1;
        end
    endtask

    task automatic adc_pulse(input int dly, input int hold);
        repeat (dly) step();
        valid = 1'b1;
        repeat (hold) step();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        run    = 1'b0;
        valid  = 1'b0;
        lo_val = 4'b0001;
        step();
        checks++;
        if ({trig, sw_pc, azmux, phase, led0, monitor, spi, fault} !==
            {1'b0, BOOT, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {trig, sw_pc, azmux, phase, led0, monitor, spi, fault},
                     {1'b0, BOOT, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0});
        end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        int n;
        bit sig;
        do_reset();
        lo_val = 4'b0001;
        run = 1'b1;
        wait_trig(40, n, sig);
        checks++;
        if (n !== 14) begin failures++; $display("FAIL seq_first_trig got=%0d exp=14", n); end
        checks++;
        if (sig !== 1'b0) begin failures++; $display("FAIL seq_sig_before_hi got=%0b exp=0", sig); end
        checks++;
        if ({sw_pc, azmux, phase, monitor} !== {SIG, HI, 1'b0, 2'b11}) begin
            failures++;
            $display("FAIL seq_hi_trig got=%b exp=%b", {sw_pc, azmux, phase, monitor}, {SIG, HI, 1'b0, 2'b11});
        end
        repeat (10) step();
        valid = 1'b1;
        step();
        checks++;
        if ({sw_pc, monitor, azmux} !== {BOOT, 2'b01, HI}) begin
            failures++;
            $display("FAIL seq_hi_accept got=%b exp=%b", {sw_pc, monitor, azmux}, {BOOT, 2'b01, HI});
        end
        step();
        checks++;
        if (spi !== 1'b0) begin failures++; $display("FAIL seq_spi_low got=%0b exp=0", spi); end
        step();
        checks++;
        if (spi !== 1'b1) begin failures++; $display("FAIL seq_spi_one_clk got=%0b exp=1", spi); end
        valid = 1'b0;
        wait_trig(40, n, sig);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL seq_lo_trig got=%0d exp=4", n); end
        checks++;
        if ({sig, sw_pc, azmux, phase, monitor, led0} !== {1'b0, BOOT, 4'b0001, 1'b1, 2'b10, 1'b0}) begin
            failures++;
            $display("FAIL seq_lo_state got=%b exp=%b", {sig, sw_pc, azmux, phase, monitor, led0},
                     {1'b0, BOOT, 4'b0001, 1'b1, 2'b10, 1'b0});
        end
        repeat (10) step();
        valid = 1'b1;
        step();
        checks++;
        if ({led0, monitor} !== {1'b1, 2'b00}) begin
            failures++;
            $display("FAIL seq_lo_accept got=%b exp=%b", {led0, monitor}, {1'b1, 2'b00});
        end
        step();
        valid = 1'b0;
        wait_trig(40, n, sig);
        checks++;
        if (n !== 6) begin failures++; $display("FAIL seq_second_hi_trig got=%0d exp=6", n); end
        checks++;
        if ({sig, sw_pc, azmux, phase} !== {1'b0, SIG, HI, 1'b0}) begin
            failures++;
            $display("FAIL seq_second_hi_state got=%b exp=%b", {sig, sw_pc, azmux, phase}, {1'b0, SIG, HI, 1'b0});
        end
        adc_pulse(10, 2);
        wait_trig(40, n, sig);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL seq_second_lo_trig got=%0d exp=5", n); end
        adc_pulse(10, 2);
        checks++;
        if (led0 !== 1'b0) begin failures++; $display("FAIL seq_led_second_pair got=%0b exp=0", led0); end
    endtask

    task automatic test_valid_held();
        int n;
        bit sig;
        do_reset();
        valid = 1'b1;
        run = 1'b1;
        wait_trig(40, n, sig);
        checks++;
        if (n !== 14) begin failures++; $display("FAIL held_trig got=%0d exp=14", n); end
        step();
        checks++;
        if ({sw_pc, monitor} !== {SIG, 2'b11}) begin
            failures++;
            $display("FAIL held_no_premature got=%b exp=%b", {sw_pc, monitor}, {SIG, 2'b11});
        end
        step();
        checks++;
        if ({sw_pc, monitor} !== {BOOT, 2'b01}) begin
            failures++;
            $display("FAIL held_accept got=%b exp=%b", {sw_pc, monitor}, {BOOT, 2'b01});
        end
        valid = 1'b0;
    endtask

    task automatic test_spi_idle();
        do_reset();
        valid = 1'b1;
        step();
        checks++;
        if (spi !== 1'b1) begin failures++; $display("FAIL spi_idle_early got=%0b exp=1", spi); end
        step();
        checks++;
        if (spi !== 1'b0) begin failures++; $display("FAIL spi_idle_pulse got=%0b exp=0", spi); end
        step();
        checks++;
        if ({spi, trig} !== 2'b10) begin failures++; $display("FAIL spi_idle_end got=%b exp=10", {spi, trig}); end
        valid = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bit sig;
        bit bad;
        do_reset();
        run = 1'b1;
        wait_trig(40, n, sig);
        repeat (20) step();
        checks++;
        if (fault !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0b exp=0", fault); end
        step();
        checks++;
        if ({fault, sw_pc, azmux, trig, monitor} !== {1'b1, BOOT, 4'b0001, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL timeout_fault got=%b exp=%b", {fault, sw_pc, azmux, trig, monitor},
                     {1'b1, BOOT, 4'b0001, 1'b0, 2'b00});
        end
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run = ~run;
            valid = i[1];
            step();
            if (fault !== 1'b1 || trig !== 1'b0 || sw_pc !== BOOT) bad = 1'b1;
        end
        valid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL timeout_sticky got=%0b exp=0", bad); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (fault !== 1'b0) begin failures++; $display("FAIL timeout_reset_clears got=%0b exp=0", fault); end
    endtask

    task automatic test_run_drop();
        int n;
        bit sig;
        do_reset();
        run = 1'b1;
        wait_trig(40, n, sig);
        run = 1'b0;
        adc_pulse(10, 2);
        wait_trig(40, n, sig);
        checks++;
        if ({n == 5, phase} !== 2'b11) begin
            failures++;
            $display("FAIL rundrop_lo_done got n=%0d phase=%0b exp n=5 phase=1", n, phase);
        end
        adc_pulse(10, 2);
        wait_trig(50, n, sig);
        checks++;
        if (n !== -1) begin failures++; $display("FAIL rundrop_idle_trig got=%0d exp=-1", n); end
        checks++;
        if (led0 !== 1'b1) begin failures++; $display("FAIL rundrop_led got=%0b exp=1", led0); end
        run = 1'b1;
        wait_trig(40, n, sig);
        checks++;
        if (n !== 14) begin failures++; $display("FAIL rundrop_restart got=%0d exp=14", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit sig;
        do_reset();
        run = 1'b1;
        wait_trig(40, n, sig);
        adc_pulse(10, 2);
        wait_trig(40, n, sig);
        adc_pulse(10, 2);
        wait_trig(40, n, sig);
        step();
        checks++;
        if ({sw_pc, led0} !== {SIG, 1'b1}) begin
            failures++;
            $display("FAIL midreset_pre got=%b exp=%b", {sw_pc, led0}, {SIG, 1'b1});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({sw_pc, trig, fault, led0, spi, monitor} !== {BOOT, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL midreset_post got=%b exp=%b", {sw_pc, trig, fault, led0, spi, monitor},
                     {BOOT, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00});
        end
        reset = 1'b0;
    endtask

    task automatic test_lo_change();
        int n;
        bit sig;
        lo_val = 4'b0001;
        do_reset();
        run = 1'b1;
        wait_trig(40, n, sig);
        lo_val = 4'b0010;
        adc_pulse(10, 2);
        wait_trig(40, n, sig);
        checks++;
        if ({azmux, phase} !== {4'b0010, 1'b1}) begin
            failures++;
            $display("FAIL lochange_azmux got=%b exp=%b", {azmux, phase}, {4'b0010, 1'b1});
        end
    endtask

    initial begin
        reset  = 1'b1;
        run    = 1'b0;
        valid  = 1'b0;
        lo_val = 4'b0001;
        test_reset();
        test_sequence();
        test_valid_held();
        test_spi_idle();
        test_timeout();
        test_run_drop();
        test_reset_mid();
        test_lo_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_modulation_az_sequencer.md
Name: sample_modulation_az_sequencer

Overview:
Auto-zero sample sequencer. Alternates the ADC between the signal (HI) and the az reference (LO) each sample pair, driving the precharge switch and azmux with guard/settle delays. It triggers the ADC, waits on its valid handshake with a watchdog, and pulses the SPI interrupt to the MCU on each completed measurement. Sits between the ADC controller and the analog switch pins, alongside the no-az modulation path.

Parameters:
PRECHARGE_CLKS, 10000, settle/guard dwell in clks (500us at 20MHz)
ADC_TIMEOUT_CLKS, 2000000, max clks from trig to valid before fault (100ms)
AZMUX_W, 4, azmux control width
AZMUX_HI_VAL, 4'b1000, azmux code selecting precharge-switch output (HI)
SW_PC_SIGNAL, 1, sw_pc_ctl level passing signal
SW_PC_BOOT, 0, sw_pc_ctl level selecting boot (protect)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = sequence continuously
azmux_lo_val  in  AZMUX_W  azmux code for LO reference, sampled when used
adc_measure_valid  in  1  ADC result valid level (high while result held)
adc_measure_trig  out  1  one-clk pulse starting an ADC measure
sw_pc_ctl  out  1  precharge switch control
azmux  out  AZMUX_W  az mux control
sample_phase  out  1  0 = current/last measure HI, 1 = LO
led0  out  1  toggles once per HI/LO pair
monitor  out  2  [0] = azmux on HI, [1] = ADC measuring
spi_interrupt_ctl  out  1  active-low one-clk pulse per valid rising edge
fault  out  1  sticky ADC timeout flag

Behaviour:
- Reset (sync, overrides all): state IDLE, count 0, adc_measure_trig 0, sw_pc_ctl SW_PC_BOOT, azmux azmux_lo_val, sample_phase 0, led0 0, monitor 0, spi_interrupt_ctl 1, fault 0, edge reg 2'b00.
- count: 32-bit down counter, decrements every clk, wraps freely, reloaded by load states. Wait-state exit when count==0, so a load of N gives 1 load clk plus N+1 wait clks.
- States and transitions:
  - IDLE: sw_pc BOOT, azmux lo. If run, go to PC_BOOT.
  - PC_BOOT: load PRECHARGE_CLKS, sw_pc BOOT. Go to PC_BOOT_W, which goes to HI_SETTLE at count==0.
  - HI_SETTLE: azmux AZMUX_HI_VAL, monitor[0]=1, load PRECHARGE_CLKS. Go to HI_SETTLE_W, which goes to HI_TRIG at 0.
  - HI_TRIG: sw_pc SIGNAL, sample_phase 0, trig=1, monitor[1]=1, load ADC_TIMEOUT_CLKS. Go to HI_WAIT.
  - HI_WAIT: trig=0. Valid accepted only when trig==0 in this clk. On valid: sw_pc BOOT, monitor[1]=0, load PRECHARGE_CLKS, go to LO_SETTLE_W.
  - LO_SETTLE_W: at 0, azmux azmux_lo_val, monitor[0]=0, go to LO_TRIG.
  - LO_TRIG: sample_phase 1, trig=1, monitor[1]=1, load ADC_TIMEOUT_CLKS. Go to LO_WAIT.
  - LO_WAIT: trig=0. On valid: monitor[1]=0, led0 toggles. Go to HI_SETTLE if run, else IDLE.
  - In either WAIT state, count==0 with no valid: go to FAULT. Valid and count==0 in the same clk counts as valid (valid wins).
  - FAULT: fault=1, sw_pc BOOT, azmux lo, trig 0, monitor 0. Stays until reset.
- sw_pc_ctl is SIGNAL only from HI_TRIG until the HI valid. It is never SIGNAL while azmux is changing.
- run is sampled only in IDLE and at LO_WAIT exit. Dropping run mid-pair completes the pair.
- spi_interrupt_ctl: edge reg <= {edge[0], adc_measure_valid}. Output is 0 for exactly one clk when edge==2'b01, otherwise 1, in every state including IDLE and FAULT. Latency: 2 clks after valid rises.
- Reset asserted mid-sequence returns outputs to reset values on the next clk edge. No partial pulse survives.

Test Plan:
- PRECHARGE_CLKS=4, run=1, ADC returns valid 10 clks after each trig: trig period alternates HI/LO. sw_pc SIGNAL only during HI; azmux=AZMUX_HI_VAL during HI; 5 wait clks before each trig; led0 toggles once per pair.
- Valid held high across trig clk: no premature acceptance; WAIT exits only after trig low and valid seen. Valid pulse 0→1 gives spi_interrupt_ctl=0 for exactly 1 clk, 2 clks after the rise.
- ADC_TIMEOUT_CLKS=20, valid never asserted: fault=1 on the 21st clk after trig. sw_pc BOOT, azmux=azmux_lo_val. Stays in FAULT with run toggled until reset.
- run dropped during HI_WAIT: LO measure still performed, then IDLE. No further trig; run reasserted restarts at PC_BOOT.
- reset asserted during HI_WAIT (sw_pc SIGNAL): next clk sw_pc BOOT, trig 0, fault 0, led0 0, spi_interrupt_ctl 1.
- azmux_lo_val changed from 4'b0001 to 4'b0010 mid-HI: next LO phase drives 4'b0010.
